// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the five-stage MIPS core: operand forwarding,
// load-use stalls, branch flushes, memory-wait freeze and saturating event counters.
module hazard_forward_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic [4:0]       ID_EX_Rs,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             ID_EX_MemRead,
  input  logic             EX_MEM_RegWrite,
  input  logic             MEM_WB_RegWrite,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic [4:0]       MEM_WB_Rd,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             EX_MEM_BranchTaken,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Bubble,
  output logic             PCSrc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             mem_timeout,
  output logic             state
);

  localparam int TMR_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           r_state, w_stateNext;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_stallCnt, r_flushCnt, r_waitCnt;
  logic             r_timeout;

  logic w_memBusy, w_loadUse, w_freeze, w_branchEv, w_stallEv;

  // EX/MEM result is younger than MEM/WB, so it takes priority.
  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    if (EX_MEM_RegWrite && EX_MEM_Rd != 5'd0 && EX_MEM_Rd == src)
      return 2'b10;
    else if (MEM_WB_RegWrite && MEM_WB_Rd != 5'd0 && MEM_WB_Rd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ForwardA = fwdSel(ID_EX_Rs);
  assign ForwardB = fwdSel(ID_EX_Rt);

  assign w_memBusy  = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready;
  assign w_loadUse  = ID_EX_MemRead & (ID_EX_Rt != 5'd0) &
                      ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt));
  assign w_freeze   = w_memBusy | ((r_state == WAIT) & ~dmem_ready);
  assign w_branchEv = EX_MEM_BranchTaken & ~w_freeze;
  assign w_stallEv  = w_loadUse & ~w_freeze & ~EX_MEM_BranchTaken;

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Flush  = 1'b0;
    MEM_WB_Bubble = 1'b0;
    PCSrc         = 1'b0;
    if (w_freeze) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (EX_MEM_BranchTaken) begin
      PCSrc        = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (w_loadUse) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN:     if (w_memBusy) w_stateNext = WAIT;
      WAIT:    if (dmem_ready) w_stateNext = RUN;
      default: w_stateNext = RUN;
    endcase
  end

  // Every frozen cycle is a wait cycle, whether it is the RUN cycle that starts the access or a WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_freeze) begin
        if (r_timer != TMR_W'(MAX_WAIT))
          r_timer <= r_timer + TMR_W'(1);
        if (r_timer >= TMR_W'(MAX_WAIT - 1))
          r_timeout <= 1'b1;
      end else if (r_state == WAIT && dmem_ready) begin
        r_timer <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
      r_waitCnt  <= '0;
    end else begin
      if (w_stallEv && !(&r_stallCnt))  r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_branchEv && !(&r_flushCnt)) r_flushCnt <= r_flushCnt + CNT_W'(1);
      if (w_freeze && !(&r_waitCnt))    r_waitCnt  <= r_waitCnt + CNT_W'(1);
    end
  end

  assign stall_cnt   = r_stallCnt;
  assign flush_cnt   = r_flushCnt;
  assign wait_cnt    = r_waitCnt;
  assign mem_timeout = r_timeout;
  assign state       = r_state;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: default and narrow (CNT_W=2, MAX_WAIT=4) instances
// driven in lockstep and compared against a cycle-level behavioural model.
module tb_hazard_forward_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ID_EX_MemRead, EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic       EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_BranchTaken, dmem_ready, cnt_clr;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, EX_MEM_Rd, MEM_WB_Rd;

  logic [1:0]  faA, fbA, faB, fbB;
  logic        pcwA, ifwA, idwA, exwA, iffA, idbA, exfA, wbbA, pcsA, toA, stA;
  logic        pcwB, ifwB, idwB, exwB, iffB, idbB, exfB, wbbB, pcsB, toB, stB;
  logic [15:0] scA, fcA, wcA;
  logic [1:0]  scB, fcB, wcB;

  hazard_forward_ctrl dutA (
    .clk(clk), .rst(rst), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .EX_MEM_Rd(EX_MEM_Rd), .MEM_WB_Rd(MEM_WB_Rd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_BranchTaken(EX_MEM_BranchTaken),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr), .ForwardA(faA), .ForwardB(fbA),
    .PCWrite(pcwA), .IF_ID_Write(ifwA), .ID_EX_Write(idwA), .EX_MEM_Write(exwA),
    .IF_ID_Flush(iffA), .ID_EX_Bubble(idbA), .EX_MEM_Flush(exfA), .MEM_WB_Bubble(wbbA),
    .PCSrc(pcsA), .stall_cnt(scA), .flush_cnt(fcA), .wait_cnt(wcA),
    .mem_timeout(toA), .state(stA)
  );

  hazard_forward_ctrl #(.CNT_W(2), .MAX_WAIT(4)) dutB (
    .clk(clk), .rst(rst), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .EX_MEM_Rd(EX_MEM_Rd), .MEM_WB_Rd(MEM_WB_Rd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_BranchTaken(EX_MEM_BranchTaken),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr), .ForwardA(faB), .ForwardB(fbB),
    .PCWrite(pcwB), .IF_ID_Write(ifwB), .ID_EX_Write(idwB), .EX_MEM_Write(exwB),
    .IF_ID_Flush(iffB), .ID_EX_Bubble(idbB), .EX_MEM_Flush(exfB), .MEM_WB_Bubble(wbbB),
    .PCSrc(pcsB), .stall_cnt(scB), .flush_cnt(fcB), .wait_cnt(wcB),
    .mem_timeout(toB), .state(stB)
  );

  int total = 0;
  int bad   = 0;

  // Model state: index 0 is dutA, index 1 is dutB.
  bit mWait;
  int mTimer;
  int mStall[2], mFlush[2], mWaitCnt[2];
  bit mTo[2];
  int cntMax[2]   = '{65535, 3};
  int waitLimit[2] = '{64, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwdModel(input logic [4:0] src);
    if (EX_MEM_RegWrite && EX_MEM_Rd != 0 && EX_MEM_Rd == src) return 2;
    if (MEM_WB_RegWrite && MEM_WB_Rd != 0 && MEM_WB_Rd == src) return 1;
    return 0;
  endfunction

  function automatic bit busyNow();
    return (EX_MEM_MemRead || EX_MEM_MemWrite) && !dmem_ready;
  endfunction

  function automatic bit frozenNow();
    return busyNow() || (mWait && !dmem_ready);
  endfunction

  function automatic bit loadUseNow();
    return ID_EX_MemRead && ID_EX_Rt != 0 && (ID_EX_Rt == IF_ID_Rs || ID_EX_Rt == IF_ID_Rt);
  endfunction

  function automatic int bump(input int c, input bit ev, input int mx);
    if (cnt_clr) return 0;
    if (ev && c < mx) return c + 1;
    return c;
  endfunction

  task automatic modelTick();
    bit fr, br, lu;
    fr = frozenNow();
    br = EX_MEM_BranchTaken && !fr;
    lu = loadUseNow() && !fr && !EX_MEM_BranchTaken;
    if (rst) begin
      mWait = 0;
      mTimer = 0;
      for (int i = 0; i < 2; i++) begin
        mStall[i] = 0; mFlush[i] = 0; mWaitCnt[i] = 0; mTo[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      mStall[i]   = bump(mStall[i], lu, cntMax[i]);
      mFlush[i]   = bump(mFlush[i], br, cntMax[i]);
      mWaitCnt[i] = bump(mWaitCnt[i], fr, cntMax[i]);
    end
    if (fr) mTimer++;
    else if (mWait && dmem_ready) mTimer = 0;
    for (int i = 0; i < 2; i++)
      if (mTimer >= waitLimit[i]) mTo[i] = 1;
    mWait = mWait ? !dmem_ready : busyNow();
  endtask

  task automatic setIdle();
    rst = 0; cnt_clr = 0; dmem_ready = 1;
    ID_EX_MemRead = 0; EX_MEM_RegWrite = 0; MEM_WB_RegWrite = 0;
    EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; EX_MEM_BranchTaken = 0;
    IF_ID_Rs = 0; IF_ID_Rt = 0; ID_EX_Rs = 0; ID_EX_Rt = 0; EX_MEM_Rd = 0; MEM_WB_Rd = 0;
  endtask

  task automatic applyStimulus();
    IF_ID_Rs = 5'($urandom_range(0, 3));
    IF_ID_Rt = 5'($urandom_range(0, 3));
    ID_EX_Rs = 5'($urandom_range(0, 3));
    ID_EX_Rt = 5'($urandom_range(0, 3));
    EX_MEM_Rd = 5'($urandom_range(0, 3));
    MEM_WB_Rd = 5'($urandom_range(0, 3));
    EX_MEM_RegWrite    = 1'($urandom_range(0, 1));
    MEM_WB_RegWrite    = 1'($urandom_range(0, 1));
    ID_EX_MemRead      = ($urandom_range(0, 2) == 0);
    EX_MEM_MemRead     = ($urandom_range(0, 4) == 0);
    EX_MEM_MemWrite    = ($urandom_range(0, 6) == 0);
    EX_MEM_BranchTaken = ($urandom_range(0, 4) == 0);
    dmem_ready         = 1'($urandom_range(0, 1));
    cnt_clr            = ($urandom_range(0, 19) == 0);
    rst                = ($urandom_range(0, 59) == 0);
  endtask

  // Checks the combinational controls for the current inputs, clocks once, then checks registered state.
  task automatic checkOutput(input string tag);
    bit fr, lu;
    logic [3:0] en;
    logic [4:0] fl;
    #1;
    fr = frozenNow();
    lu = loadUseNow();
    if (fr)                      begin en = 4'b0000; fl = 5'b00010; end
    else if (EX_MEM_BranchTaken) begin en = 4'b1111; fl = 5'b11101; end
    else if (lu)                 begin en = 4'b0011; fl = 5'b01000; end
    else                         begin en = 4'b1111; fl = 5'b00000; end
    chk({tag, ".fwdA.A"}, 32'(faA), 32'(fwdModel(ID_EX_Rs)));
    chk({tag, ".fwdB.A"}, 32'(fbA), 32'(fwdModel(ID_EX_Rt)));
    chk({tag, ".fwdA.B"}, 32'(faB), 32'(fwdModel(ID_EX_Rs)));
    chk({tag, ".en.A"}, 32'({pcwA, ifwA, idwA, exwA}), 32'(en));
    chk({tag, ".en.B"}, 32'({pcwB, ifwB, idwB, exwB}), 32'(en));
    chk({tag, ".fl.A"}, 32'({iffA, idbA, exfA, wbbA, pcsA}), 32'(fl));
    chk({tag, ".fl.B"}, 32'({iffB, idbB, exfB, wbbB, pcsB}), 32'(fl));
    @(posedge clk);
    modelTick();
    #1;
    chk({tag, ".state.A"}, 32'(stA), 32'(mWait));
    chk({tag, ".state.B"}, 32'(stB), 32'(mWait));
    chk({tag, ".to.A"}, 32'(toA), 32'(mTo[0]));
    chk({tag, ".to.B"}, 32'(toB), 32'(mTo[1]));
    chk({tag, ".stall.A"}, 32'(scA), 32'(mStall[0]));
    chk({tag, ".stall.B"}, 32'(scB), 32'(mStall[1]));
    chk({tag, ".flush.A"}, 32'(fcA), 32'(mFlush[0]));
    chk({tag, ".flush.B"}, 32'(fcB), 32'(mFlush[1]));
    chk({tag, ".wait.A"}, 32'(wcA), 32'(mWaitCnt[0]));
    chk({tag, ".wait.B"}, 32'(wcB), 32'(mWaitCnt[1]));
    @(negedge clk);
  endtask

  initial begin
    setIdle();
    mWait = 0; mTimer = 0;
    @(negedge clk);
    rst = 1;
    checkOutput("reset");
    setIdle();
    checkOutput("idle");

    EX_MEM_Rd = 5; MEM_WB_Rd = 5; EX_MEM_RegWrite = 1; MEM_WB_RegWrite = 1;
    ID_EX_Rs = 5; ID_EX_Rt = 5;
    checkOutput("fwd_exmem");
    EX_MEM_RegWrite = 0;
    checkOutput("fwd_memwb");
    EX_MEM_RegWrite = 1; EX_MEM_Rd = 0; MEM_WB_Rd = 0;
    checkOutput("fwd_rd0");

    setIdle();
    ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rt = 8;
    checkOutput("loaduse");
    ID_EX_MemRead = 0;
    checkOutput("loaduse_after");

    ID_EX_MemRead = 1; EX_MEM_BranchTaken = 1;
    checkOutput("branch_lu");
    setIdle();

    cnt_clr = 1;
    checkOutput("clr");
    cnt_clr = 0; EX_MEM_MemRead = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) checkOutput("memwait");
    EX_MEM_BranchTaken = 1;
    checkOutput("branch_frozen");
    dmem_ready = 1;
    checkOutput("mem_ready");
    setIdle();
    checkOutput("mem_done");

    EX_MEM_MemWrite = 1; dmem_ready = 0;
    for (int i = 0; i < 70; i++) checkOutput("timeout");
    dmem_ready = 1;
    checkOutput("timeout_ready");
    setIdle();
    checkOutput("timeout_sticky");
    EX_MEM_MemRead = 1; dmem_ready = 0;
    checkOutput("wait_again");
    rst = 1;
    checkOutput("rst_midwait");
    setIdle();
    checkOutput("after_rst");

    ID_EX_MemRead = 1; ID_EX_Rt = 3; IF_ID_Rs = 3;
    for (int i = 0; i < 5; i++) checkOutput("sat");
    cnt_clr = 1;
    checkOutput("clr_vs_stall");
    setIdle();

    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      checkOutput("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the five-stage MIPS core; the EX-side consumer of the ID/EX register's Rs/Rt/MemRead fields. It generates forwarding selects for the EX-stage ALU operands, stalls for load-use hazards, flushes on branches taken in MEM, and freezes the pipeline during multi-cycle data-memory accesses. Saturating event counters expose stall, flush and wait statistics for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of each saturating event counter
- MAX_WAIT, 64, memory-wait cycles before mem_timeout is raised

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- IF_ID_Rs, IF_ID_Rt  input  5 each  source registers of the instruction in ID
- ID_EX_Rs, ID_EX_Rt  input  5 each  source registers of the instruction in EX
- ID_EX_MemRead  input  1  instruction in EX is a load
- EX_MEM_RegWrite, MEM_WB_RegWrite  input  1 each  write-back enables
- EX_MEM_Rd, MEM_WB_Rd  input  5 each  destination registers
- EX_MEM_MemRead, EX_MEM_MemWrite  input  1 each  MEM-stage access
- EX_MEM_BranchTaken  input  1  Branch & Zero in MEM
- dmem_ready  input  1  data memory completes this cycle
- cnt_clr  input  1  synchronous counter clear
- ForwardA, ForwardB  output  2 each  00 register file, 10 EX/MEM, 01 MEM/WB
- PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  output  1 each  stage-register enables
- IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush, MEM_WB_Bubble  output  1 each  zero control fields
- PCSrc  output  1  select branch target
- stall_cnt, flush_cnt, wait_cnt  output  CNT_W each  event counters
- mem_timeout  output  1  sticky error
- state  output  1  0 RUN, 1 WAIT

## Operation
- Forwarding (combinational, independent of state): ForwardA=10 if EX_MEM_RegWrite && EX_MEM_Rd!=0 && EX_MEM_Rd==ID_EX_Rs; else 01 if MEM_WB_RegWrite && MEM_WB_Rd!=0 && MEM_WB_Rd==ID_EX_Rs; else 00. ForwardB identical using ID_EX_Rt. EX/MEM wins over MEM/WB.
- mem_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready.
- load_use = ID_EX_MemRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt).
- Priority each cycle: freeze > branch > load-use > normal.
  - Freeze (mem_busy or state WAIT with dmem_ready=0): all *_Write=0, MEM_WB_Bubble=1, all flushes/PCSrc=0.
  - Branch (EX_MEM_BranchTaken, not frozen): PCSrc=1, IF_ID_Flush=ID_EX_Bubble=EX_MEM_Flush=1, all enables=1; flush_cnt++.
  - Load-use (not frozen, no branch): PCWrite=IF_ID_Write=0, ID_EX_Bubble=1, ID_EX_Write=EX_MEM_Write=1; stall_cnt++.
  - Normal: all enables 1, all flushes/bubbles/PCSrc 0.
- FSM: RUN -> WAIT when mem_busy. WAIT: each cycle with dmem_ready=0 increments wait_cnt and internal timer; dmem_ready=1 -> RUN same edge, timer cleared; freeze deasserts in that cycle (access completes). RUN cycle with mem_busy also counts one wait_cnt.
- Timeout: timer reaching MAX_WAIT sets mem_timeout; stays set until rst; FSM stays in WAIT.
- Counters saturate at all-ones; cnt_clr zeroes stall/flush/wait counters (not mem_timeout), and takes precedence over increment in the same cycle.

## Timing
- Reset (rst high at clk edge): state=RUN, counters=0, timer=0, mem_timeout=0. Combinational outputs follow inputs from the next cycle; with idle inputs: ForwardA/B=00, enables=1, flushes/bubbles/PCSrc=0.
- Control outputs are combinational from inputs and state: zero-cycle latency, effective at the next clk edge in the stage registers.
- Counters and mem_timeout update on the edge ending the event cycle (visible one cycle later).
- Load-use stall lasts exactly one cycle: bubble clears ID_EX_MemRead next cycle.
- Branch taken during a freeze is deferred; EX/MEM holds, branch acts in the first unfrozen cycle.
- rst mid-WAIT returns to RUN immediately, pending access abandoned.

## Test plan
- Forward: EX_MEM_Rd=5, MEM_WB_Rd=5, both RegWrite, ID_EX_Rs=5 -> ForwardA=10; EX_MEM_RegWrite=0 -> 01; Rd=0 -> 00.
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rt=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for one cycle; stall_cnt 0->1.
- Branch + load-use same cycle -> PCSrc=1, three flushes, stall_cnt unchanged, flush_cnt+1.
- Memory wait: EX_MEM_MemRead=1, dmem_ready low 3 cycles then high -> 3 frozen cycles, state WAIT, wait_cnt=3, unfrozen on the ready cycle, RUN after.
- Timeout: MAX_WAIT=4, dmem_ready held low -> mem_timeout rises after 4 wait cycles, stays set after ready until rst.
- Saturation/clear: CNT_W=2, 5 stalls -> stall_cnt=3; cnt_clr with stall same cycle -> 0.
